// File: rtl/clock_display_if.sv
// clock_display_if: binary time inputs, buttons and seven-segment outputs of the display back end
interface clock_display_if;
  logic [5:0] sec, min;
  logic [4:0] hr;
  logic am2pm, set_mode;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  logic pm_led, busy;
  modport master (
    output sec, min, hr, am2pm, set_mode,
    input hex0, hex1, hex2, hex3, hex4, hex5, pm_led, busy
  );
  modport slave (
    input sec, min, hr, am2pm, set_mode,
    output hex0, hex1, hex2, hex3, hex4, hex5, pm_led, busy
  );
endinterface

// File: rtl/clock_display.sv
// clock_display: synchronises time inputs, converts them to BCD and drives six active-low seven-segment digits
module clock_display #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input logic clk,
  input logic rst,
  clock_display_if.slave bus
);
  localparam int HALF = (CLK_HZ / (2 * BLINK_HZ)) > 0 ? CLK_HZ / (2 * BLINK_HZ) : 1;
  localparam int DW = HALF > 1 ? $clog2(HALF) : 1;
  localparam logic [6:0] BLANK = 7'h7F, DASH = 7'h3F;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                     7'h00, 7'h10, BLANK, BLANK, BLANK, BLANK, BLANK, BLANK};
  // time bits reset to the same invalid code as t_last so reset itself never triggers a conversion
  localparam logic [18:0] SYNC_RST = {2'b00, 17'h1FFFF};
  typedef enum logic [2:0] {IDLE, SEC, MIN, HR, COMMIT} state_t;
  state_t state, state_nx;
  logic [18:0] s1, s2;
  logic [16:0] t_s, t_prev, t_last;
  logic am_s, set_s, am_prev, mode_12h, last_mode, mode_w, blink_phase, pm_q, go, bad;
  logic [DW-1:0] div;
  logic [5:0] sec_w, min_w, rem;
  logic [4:0] hr_w, hr_adj;
  logic [2:0] tens;
  logic [3:0] s_t, s_o, m_t, m_o, h_t, h_o;
  logic [6:0] d [6];
  always_comb begin
    t_s = s2[16:0];
    am_s = s2[17];
    set_s = s2[18];
    go = (t_s == t_prev) && (t_s != t_last || mode_12h != last_mode);
    hr_adj = !mode_w ? hr_w : hr_w == 5'd0 ? 5'd12 : hr_w > 5'd12 ? hr_w - 5'd12 : hr_w;
    bad = sec_w > 6'd59 || min_w > 6'd59 || hr_w > 5'd23;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = go ? SEC : IDLE;
      SEC:     state_nx = rem >= 6'd10 ? SEC : MIN;
      MIN:     state_nx = rem >= 6'd10 ? MIN : HR;
      HR:      state_nx = rem >= 6'd10 ? HR : COMMIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= SYNC_RST;
      s2 <= SYNC_RST;
      t_prev <= '1;
      t_last <= '1;
      am_prev <= 1'b0;
      mode_12h <= 1'b0;
      last_mode <= 1'b0;
      div <= '0;
      blink_phase <= 1'b0;
      sec_w <= '0;
      min_w <= '0;
      hr_w <= '0;
      mode_w <= 1'b0;
      rem <= '0;
      tens <= '0;
      {s_t, s_o, m_t, m_o, h_t, h_o} <= '0;
      d <= '{default: BLANK};
      pm_q <= 1'b0;
    end else begin
      s1 <= {bus.set_mode, bus.am2pm, bus.hr, bus.min, bus.sec};
      s2 <= s1;
      t_prev <= t_s;
      am_prev <= am_s;
      if (am_s && !am_prev) mode_12h <= !mode_12h;
      if (!set_s) begin
        div <= '0;
        blink_phase <= 1'b0;
      end else if (div == DW'(HALF - 1)) begin
        div <= '0;
        blink_phase <= !blink_phase;
      end else div <= div + DW'(1);
      if (state == IDLE) begin
        if (go) begin
          {hr_w, min_w, sec_w} <= t_s;
          mode_w <= mode_12h;
          rem <= t_s[5:0];
          tens <= '0;
        end
      end else if (state == COMMIT) begin
        d[0] <= bad ? DASH : SEG[s_o];
        d[1] <= bad ? DASH : SEG[s_t];
        d[2] <= bad ? DASH : SEG[m_o];
        d[3] <= bad ? DASH : SEG[m_t];
        d[4] <= bad ? DASH : SEG[h_o];
        d[5] <= bad ? DASH : (mode_w && h_t == 4'd0) ? BLANK : SEG[h_t];
        pm_q <= !bad && mode_w && hr_w >= 5'd12;
        t_last <= {hr_w, min_w, sec_w};
        last_mode <= mode_w;
      end else if (rem >= 6'd10) begin
        rem <= rem - 6'd10;
        tens <= tens + 3'd1;
      end else begin
        if (state == SEC) {s_t, s_o} <= {1'b0, tens, rem[3:0]};
        if (state == MIN) {m_t, m_o} <= {1'b0, tens, rem[3:0]};
        if (state == HR) {h_t, h_o} <= {1'b0, tens, rem[3:0]};
        rem <= state == SEC ? min_w : {1'b0, hr_adj};
        tens <= '0;
      end
    end
  always_comb begin
    bus.busy = state != IDLE;
    bus.pm_led = pm_q;
    bus.hex0 = d[0];
    bus.hex1 = d[1];
    bus.hex2 = blink_phase ? BLANK : d[2];
    bus.hex3 = blink_phase ? BLANK : d[3];
    bus.hex4 = blink_phase ? BLANK : d[4];
    bus.hex5 = blink_phase ? BLANK : d[5];
  end
endmodule
